// File: rtl/ram1_access_arbiter_pkg.sv
// rtl/ram1_access_arbiter_pkg.sv - shared constants and FSM encoding for the Ram1 access arbiter
// Contents: default bus widths, requester port indices, transaction FSM state encoding.
package ram1_access_arbiter_pkg;

  localparam int DEF_ADDR_W = 18;
  localparam int DEF_DATA_W = 16;

  // Bit positions of each requester in the one-hot grant vector.
  localparam int PORT0_IDX = 0;
  localparam int PORT1_IDX = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

endpackage

// File: rtl/ram1_rr_picker.sv
// rtl/ram1_rr_picker.sv - combinational two-way winner selection for the Ram1 arbiter
// Ports: req0/req1 requests in; last_grant in (1 = port 1 was granted last);
//        fixed_prio in (1 = port 0 always wins a tie); winner out (one-hot, 00 when idle).
module ram1_rr_picker
  import ram1_access_arbiter_pkg::*;
(
  input  logic       req0,
  input  logic       req1,
  input  logic       last_grant,
  input  logic       fixed_prio,
  output logic [1:0] winner
);

  always_comb begin
    winner = 2'b00;
    if (req0 && req1) begin
      // Tie: fixed priority favours port 0, otherwise hand it to whoever did not go last.
      if (fixed_prio || last_grant) begin
        winner[PORT0_IDX] = 1'b1;
      end else begin
        winner[PORT1_IDX] = 1'b1;
      end
    end else if (req0) begin
      winner[PORT0_IDX] = 1'b1;
    end else if (req1) begin
      winner[PORT1_IDX] = 1'b1;
    end
  end

endmodule

// File: rtl/ram1_access_arbiter.sv
// rtl/ram1_access_arbiter.sv - two-port arbiter and setup/strobe/finish sequencer for the Ram1 SRAM
// Ports: CLK, RST (sync, active-low); per port reqN/weN/addrN/wdataN in, ackN out (1-cycle pulse);
//        rdata out (held until next read); busy/grant status out;
//        Ram1Addr/Ram1Data/Ram1OE/Ram1WE/Ram1EN to the SRAM pins (strobes active-low).
module ram1_access_arbiter
  import ram1_access_arbiter_pkg::*;
#(
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter int DATA_W        = DEF_DATA_W,
  parameter int STROBE_CYCLES = 1,
  parameter int FIXED_PRIO    = 0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [1:0]        grant,
  output logic [ADDR_W-1:0] Ram1Addr,
  inout  wire  [DATA_W-1:0] Ram1Data,
  output logic              Ram1OE,
  output logic              Ram1WE,
  output logic              Ram1EN
);

  // Down-counter reload: STROBE exits when the counter reaches zero.
  localparam logic [2:0] STROBE_LOAD = 3'(STROBE_CYCLES - 1);

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        grant_q, grant_d;
  logic              last_grant_q, last_grant_d;
  logic [1:0]        winner;

  ram1_rr_picker u_picker (
    .req0       (req0),
    .req1       (req1),
    .last_grant (last_grant_q),
    .fixed_prio (FIXED_PRIO != 0),
    .winner     (winner)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ST_IDLE: begin
        if (winner != 2'b00) begin
          // Snapshot the winner's command; the input ports are ignored until the next IDLE.
          grant_d      = winner;
          last_grant_d = winner[PORT1_IDX];
          we_d         = winner[PORT0_IDX] ? we0    : we1;
          addr_d       = winner[PORT0_IDX] ? addr0  : addr1;
          wdata_d      = winner[PORT0_IDX] ? wdata0 : wdata1;
          state_d      = ST_SETUP;
        end
      end
      ST_SETUP: begin
        cnt_d   = STROBE_LOAD;
        state_d = ST_STROBE;
      end
      ST_STROBE: begin
        if (cnt_q == 3'd0) begin
          // Sample the SRAM while OE is still low.
          if (!we_q) begin
            rdata_d = Ram1Data;
          end
          state_d = ST_FINISH;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_FINISH: begin
        grant_d = 2'b00;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 3'd0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      grant_q      <= 2'b00;
      last_grant_q <= 1'b1;  // pretend port 1 went last so port 0 wins the first tie
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign grant    = grant_q;
  assign rdata    = rdata_q;
  assign ack0     = (state_q == ST_FINISH) && grant_q[PORT0_IDX];
  assign ack1     = (state_q == ST_FINISH) && grant_q[PORT1_IDX];
  assign Ram1Addr = addr_q;
  assign Ram1EN   = (state_q == ST_IDLE);
  assign Ram1WE   = !((state_q == ST_STROBE) && we_q);
  assign Ram1OE   = !((state_q == ST_STROBE) && !we_q);
  // Write data is driven from SETUP through FINISH so it brackets the WE pulse on both sides.
  assign Ram1Data = (busy && we_q) ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: doc/ram1_access_arbiter.md
Name: ram1_access_arbiter

Overview:
Sequences every access to the external SRAM bank Ram1 and shares it between two requesters: port 0 for the switch/controller path and port 1 for a second master such as fetch or debug. Each request runs through a fixed setup/strobe/finish cycle that generates Ram1EN/Ram1OE/Ram1WE and tri-states Ram1Data. The block sits between the top-level Controller logic and the Ram1 pins.

Parameters:
ADDR_W, 18, Ram1 address width
DATA_W, 16, Ram1 data width
STROBE_CYCLES, 1, cycles Ram1WE/Ram1OE stay low; legal range 1..7
FIXED_PRIO, 0, 0 = round-robin between ports; 1 = port 0 always wins

Ports:
CLK  in  1  system clock; all logic on rising edge
RST  in  1  reset, synchronous, active-low (RST=0 resets at the next CLK rising edge)
req0  in  1  port 0 request; held high until ack0
we0  in  1  port 0: 1 = write, 0 = read
addr0  in  ADDR_W  port 0 address
wdata0  in  DATA_W  port 0 write data
ack0  out  1  one-cycle completion pulse for port 0
req1/we1/addr1/wdata1/ack1  same as port 0, for port 1
rdata  out  DATA_W  read data; valid in the ack cycle, held until the next read completes
busy  out  1  high in every state except IDLE
grant  out  2  one-hot owner of the current transaction; 00 in IDLE
Ram1Addr  out  ADDR_W  SRAM address
Ram1Data  inout  DATA_W  SRAM data; driven only during writes
Ram1OE  out  1  output enable, active-low
Ram1WE  out  1  write enable, active-low
Ram1EN  out  1  chip enable, active-low

Behaviour:
- Reset values: Ram1EN=1, Ram1OE=1, Ram1WE=1, Ram1Data=Z, Ram1Addr=0, ack0=ack1=0, rdata=0, busy=0, grant=00, state=IDLE, last_grant=port 1 (so port 0 wins the first tie).
- FSM states: IDLE, SETUP, STROBE, FINISH.
- IDLE: if any req is high, pick the winner, then latch we, addr and wdata from that port into internal registers. Next state is SETUP. Otherwise stay in IDLE.
- Arbitration when both ports request:
  - FIXED_PRIO=0: grant the port that is not last_grant.
  - FIXED_PRIO=1: port 0 wins.
  - last_grant updates on every grant.
- SETUP (1 cycle): Ram1EN=0; Ram1Addr=latched addr. For a write, Ram1Data=latched wdata. OE and WE stay high.
- STROBE (STROBE_CYCLES cycles, counted by a 3-bit down-counter): write drives Ram1WE=0; read drives Ram1OE=0 with Ram1Data=Z. On the clock edge that leaves the last STROBE cycle, a read captures Ram1Data into rdata.
- FINISH (1 cycle): Ram1WE=1 and Ram1OE=1. A write keeps driving Ram1Data (data hold). Ram1EN=0. The granted ack is pulsed high. Next state is IDLE.
- Write timing: address and data are stable for one cycle before Ram1WE falls and one cycle after it rises.
- Latency: a request first seen in IDLE at cycle t gets its ack at cycle t+2+STROBE_CYCLES. Back-to-back transactions are separated by exactly one IDLE cycle.
- Ram1EN returns to 1 in IDLE. Ram1Addr holds its last value in IDLE.
- Requester rules:
  - Dropping req mid-transaction has no effect; the transaction completes and ack still pulses.
  - The requester must deassert req (or present the next request) in the cycle after ack.
  - A req still high in the IDLE cycle after ack starts a new transaction.
- The latched copies of addr, we and wdata are used after IDLE; changes on the input ports mid-transaction are ignored.
- RST=0 mid-transaction: at that edge all outputs take their reset values (Ram1WE rises, Ram1Data goes Z). No ack is issued and the transaction is abandoned.
- A STROBE_CYCLES value outside 1..7 is illegal and is not supported.

Decomposition:
- Shared package holds:
  - FSM state encoding constants (IDLE=2'd0, SETUP=2'd1, STROBE=2'd2, FINISH=2'd3).
  - Default ADDR_W/DATA_W.
  - Port index constants.
- One sub-module, ram1_rr_picker: combinational two-way picker. Inputs: req0, req1, last_grant, FIXED_PRIO. Output: one-hot winner.
- The last_grant register stays in ram1_access_arbiter.

Test Plan:
- Port 0 write, addr=0x000F9, wdata=0x0007, STROBE_CYCLES=1 -> Ram1EN low for 3 cycles; Ram1WE low exactly 1 cycle; Ram1Data=0x0007 in SETUP/STROBE/FINISH; ack0 at t+3; grant=01.
- Ten sequential port 0 writes to 0x0F9..0x102 with data 7,9,8,6,4,5,1,2,0,3, then ten reads -> each rdata matches in order with ack0; one IDLE cycle between transactions.
- req0 and req1 high together, continuously -> grants alternate 01,10,01,10; with FIXED_PRIO=1 only port 0 is served while req0 is held.
- STROBE_CYCLES=3, port 1 read from 0x00010 where the SRAM model returns 0xBEEF -> Ram1OE low for exactly 3 cycles, Ram1Data=Z throughout, rdata=0xBEEF with ack1 at t+5.
- RST=0 during STROBE of a write -> at the next edge Ram1WE=1, Ram1EN=1, Ram1Data=Z, busy=0, no ack; the next request after RST=1 is granted to port 0.
- Port 0 drops req0 in the cycle after grant -> transaction still completes and ack0 pulses once; req0 held one cycle past ack0 -> a second transaction starts.
